// File: rtl/posit_to_float_arb.sv
// posit_to_float_arb: round-robin arbiter sharing one two-stage posit-to-float pipeline
// Optional per-requester accept and stall counters: define POSIT_TO_FLOAT_ARB_STATS_EN.

// posit_to_fir: decode a posit into sign, special flags, scale and left-aligned fraction
module posit_to_fir #(
   parameter int N  = 16,
   parameter int ES = 1,
   parameter int SW = $clog2(N) + ES + 2
) (
   input  logic                 [N-1:0]    p,
   output logic                            sign,
   output logic                            zero,
   output logic                            nar,
   output logic signed          [SW-1:0]   scale,
   output logic                 [N-2-ES:0] frac
);
   localparam int RW = $clog2(N) + 1;
   logic [N-2:0] body, rem;
   logic [RW-1:0] run;
   logic stop;
   logic signed [SW-1:0] k;
   // regime run length, exponent and fraction extraction on the magnitude
   always_comb begin
      body = p[N-1] ? -p[N-2:0] : p[N-2:0];
      run = '0;
      stop = 1'b0;
      for (int i = N-2; i >= 0; i--)
         if (!stop && body[i] == body[N-2]) run = run + 1'b1;
         else stop = 1'b1;
      k = body[N-2] ? SW'(run) - SW'(1) : -SW'(run);
      rem = body << (run + 1'b1);
      scale = (k <<< ES) + SW'(rem[N-2 -: ES]);
   end
   assign frac = rem[N-2-ES:0];
   assign sign = p[N-1];
   assign zero = p == '0;
   assign nar  = p == {1'b1, {(N-1){1'b0}}};
endmodule

// fir_to_float: pack sign/scale/fraction into IEEE bits, round-to-nearest-even, flush underflow
module fir_to_float #(
   parameter int N     = 16,
   parameter int ES    = 1,
   parameter int FSIZE = 32,
   parameter int SW    = $clog2(N) + ES + 2
) (
   input  logic                        sign,
   input  logic                        zero,
   input  logic                        nar,
   input  logic signed [SW-1:0]        scale,
   input  logic        [N-2-ES:0]      frac,
   output logic        [FSIZE-1:0]     f
);
   localparam int EW   = FSIZE == 16 ? 5 : FSIZE == 32 ? 8 : 11;
   localparam int MW   = FSIZE - 1 - EW;
   localparam int BIAS = 2**(EW-1) - 1;
   localparam int EMAX = 2**EW - 1;
   localparam int XW   = N - 1 - ES + MW + 2;
   localparam int EBW  = SW + EW + 2;
   logic [XW-1:0] x;
   logic [MW-1:0] mant, m;
   logic rup, carry;
   logic signed [EBW-1:0] be;
   // mantissa rounding, exponent biasing and special-case selection
   always_comb begin
      x = {frac, {(MW+2){1'b0}}};
      mant = x[XW-1 -: MW];
      rup = x[XW-1-MW] & ((|x[XW-2-MW:0]) | mant[0]);
      {carry, m} = {1'b0, mant} + (MW+1)'(rup);
      be = EBW'(scale) + EBW'(BIAS) + EBW'(carry);
      f = nar ? {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}} :
          zero ? '0 :
          int'(be) >= EMAX ? {sign, {EW{1'b1}}, {MW{1'b0}}} :
          int'(be) <= 0 ? {sign, {(FSIZE-1){1'b0}}} :
          {sign, be[EW-1:0], m};
   end
endmodule

// posit_to_float: combinational posit to IEEE float conversion
module posit_to_float #(
   parameter int N     = 16,
   parameter int ES    = 1,
   parameter int FSIZE = 32
) (
   input  logic [N-1:0]     posit,
   output logic [FSIZE-1:0] f
);
   localparam int SW = $clog2(N) + ES + 2;
   logic sign, zero, nar;
   logic signed [SW-1:0] scale;
   logic [N-2-ES:0] frac;
   posit_to_fir #(.N(N), .ES(ES), .SW(SW)) u_fir (
      .p(posit), .sign(sign), .zero(zero), .nar(nar), .scale(scale), .frac(frac)
   );
   fir_to_float #(.N(N), .ES(ES), .FSIZE(FSIZE), .SW(SW)) u_flt (
      .sign(sign), .zero(zero), .nar(nar), .scale(scale), .frac(frac), .f(f)
   );
endmodule

// posit_to_float_arb: arbitration, handshakes and the A/B pipeline registers
module posit_to_float_arb #(
   parameter int N       = 16,
   parameter int ES      = 1,
   parameter int FSIZE   = 32,
   parameter int NUM_REQ = 2,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*N-1:0]   req_posit,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   rsp_valid,
   output logic [FSIZE-1:0]       rsp_float,
   output logic [IDW-1:0]         rsp_id,
   input  logic                   rsp_ready,
   output logic                   busy
`ifdef POSIT_TO_FLOAT_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]  stat_accept,
   output logic [15:0]            stat_stall
`endif
);
   logic valid_a, valid_b, pop, b_free, a_free, any, accept;
   logic [N-1:0] posit_a;
   logic [IDW-1:0] id_a, id_b, ptr, grant, nxt;
   logic [FSIZE-1:0] float_b, conv;
   logic [NUM_REQ-1:0] rot;
   logic [IDW:0] off, sum;

   assign pop    = valid_b & rsp_ready;
   assign b_free = ~valid_b | pop;
   assign a_free = ~valid_a | b_free;

   // rotate requests so ptr sits at bit 0, pick the lowest set bit, rotate back
   always_comb begin
      rot = NUM_REQ'({req_valid, req_valid} >> ptr);
      off = '0;
      any = 1'b0;
      for (int j = NUM_REQ-1; j >= 0; j--)
         if (rot[j]) begin
            off = (IDW+1)'(j);
            any = 1'b1;
         end
      sum = {1'b0, ptr} + off;
      grant = sum >= (IDW+1)'(NUM_REQ) ? IDW'(sum - (IDW+1)'(NUM_REQ)) : IDW'(sum);
      nxt = grant == IDW'(NUM_REQ-1) ? '0 : grant + 1'b1;
      req_ready = (any & rst_n & a_free) ? NUM_REQ'(1) << grant : '0;
   end

   assign accept = |(req_valid & req_ready);

   posit_to_float #(.N(N), .ES(ES), .FSIZE(FSIZE)) u_conv (.posit(posit_a), .f(conv));

   // pipeline advance: B pops/refills from A, A refills from the granted requester
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_a <= 1'b0;
         valid_b <= 1'b0;
         posit_a <= '0;
         id_a    <= '0;
         id_b    <= '0;
         float_b <= '0;
         ptr     <= '0;
      end else begin
         if (b_free) begin
            valid_b <= valid_a;
            if (valid_a) begin
               float_b <= conv;
               id_b    <= id_a;
            end
         end
         if (a_free) begin
            valid_a <= accept;
            if (accept) begin
               posit_a <= req_posit[grant*N +: N];
               id_a    <= grant;
               ptr     <= nxt;
            end
         end
      end
   end

   assign rsp_valid = valid_b;
   assign rsp_float = float_b;
   assign rsp_id    = id_b;
   assign busy      = valid_a | valid_b;

`ifdef POSIT_TO_FLOAT_ARB_STATS_EN
   logic [15:0] acc_cnt [NUM_REQ];
   logic [15:0] stall_cnt;
   // saturating per-requester accept counters and output stall counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) acc_cnt[i] <= '0;
         stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++)
            if (accept && grant == IDW'(i) && acc_cnt[i] != 16'hFFFF) acc_cnt[i] <= acc_cnt[i] + 1'b1;
         if (valid_b && !rsp_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
      end
   end
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      assign stat_accept[g*16 +: 16] = acc_cnt[g];
   end
   assign stat_stall = stall_cnt;
`endif
endmodule

// File: doc/posit_to_float_arb.md
# posit_to_float_arb

Round-robin arbiter and two-stage pipeline controller that shares one `posit_to_float` conversion datapath (`posit_to_fir` → `fir_to_float`) between `NUM_REQ` requesters. It sits between the PPU's posit-side clients (for example the issue port and a debug/CSR read port) and the float-side consumer. It handles valid/ready handshakes on both sides, tags each result with the requester index, and sustains one conversion per cycle under full load.

## Interface
Parameters:
- `N`, default 16: posit width.
- `ES`, default 1: posit exponent size.
- `FSIZE`, default 32: float width; legal values are 16, 32 and 64.
- `NUM_REQ`, default 2: number of requesters; legal range is 2..8.
- `IDW`, default `$clog2(NUM_REQ)`: width of the requester tag.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  `NUM_REQ`  per-requester request valid.
- `req_posit`  in  `NUM_REQ*N`  requester i drives `[i*N +: N]`.
- `req_ready`  out  `NUM_REQ`  one-hot or zero; the request is accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  1  result valid.
- `rsp_float`  out  `FSIZE`  converted float bits.
- `rsp_id`  out  `IDW`  index of the requester that issued the result.
- `rsp_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high when either pipeline stage holds a valid entry.

## Operation
- Stage A register holds `{posit, id, valid_a}`. Stage B register holds `{float, id, valid_b}`.
- One `posit_to_float` instance converts combinationally from the stage A posit to the stage B input.
- Stage B movement:
  - `pop = valid_b & rsp_ready`.
  - `b_free = ~valid_b | pop`.
  - A moves to B when `valid_a & b_free`.
- Stage A acceptance: `a_free = ~valid_a | (valid_a & b_free)`.
- Arbitration uses round-robin pointer `ptr` (width `IDW`). The grant goes to the first i with `req_valid[i]`, scanning `ptr, ptr+1, … ptr+NUM_REQ-1` (mod `NUM_REQ`).
- `req_ready[grant] = a_free`. All other bits of `req_ready` are 0. If no request is valid, `req_ready` is all 0.
- On acceptance, `ptr` becomes `grant+1` mod `NUM_REQ`. Without an acceptance, `ptr` holds.
- Fairness: under continuous requests from all requesters, each requester is granted exactly once per `NUM_REQ` accepts.
- The grant decision is based only on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- `req_ready` depends combinationally on `rsp_ready` through `b_free`. This path is intended.
- While `rsp_valid & ~rsp_ready`, `rsp_float` and `rsp_id` stay stable.
- Conversion semantics (zero, NaR, rounding) are exactly those of the existing `posit_to_float` datapath. No additional handling is added here.

## Timing
- Reset values: `valid_a=0`, `valid_b=0`, `ptr=0`, `rsp_valid=0`, `rsp_float=0`, `rsp_id=0`, `busy=0`. While reset is asserted, `req_ready=0`.
- Assertion of `rst_n` mid-operation immediately discards both in-flight entries. No result is produced for them.
- Latency: a request accepted at edge t sets `valid_a` after t. `rsp_valid` is asserted in the cycle after edge t+1.
- Throughput: 1 accept per cycle while `rsp_ready=1`.
- Full pipeline, `rsp_ready=0`: both stages are valid, `req_ready=0`, and nothing moves.
- Full pipeline, `rsp_ready=1`: pop, A→B and a new accept all happen on the same edge.
- Stage B empty, stage A valid: A moves to B regardless of `rsp_ready`.

## Configuration
- Feature macro: `POSIT_TO_FLOAT_ARB_STATS_EN`.
- With the macro defined:
  - Extra output `stat_accept` (`NUM_REQ*16` bits): per-requester accept counters, saturating at 0xFFFF.
  - Extra output `stat_stall` (16 bits): counts cycles with `valid_b & ~rsp_ready`, saturating.
  - All counters reset to 0 on `rst_n` low.
- Without the macro: these ports and counters do not exist, and the rest of the behaviour is identical.

## Test plan
All scenarios use N=16, ES=1, FSIZE=32, NUM_REQ=2.
- Single request: req0 sends 0x4000 with `rsp_ready=1` → `rsp_valid` 2 cycles after acceptance, `rsp_float`=0x3F800000, `rsp_id`=0.
- Contention: req0 and req1 held valid continuously, with req0=0x5000 and req1=0x6000 → results alternate id0/id1, first id0. Values 0x40000000 and 0x40800000. One result per cycle.
- Backpressure: stream of 4 requests from req1 (0xC000, 0x0000, 0x4000, 0x6000) with `rsp_ready` low for 3 cycles after the first `rsp_valid` → `req_ready` drops after 2 accepts and the output is held. Results 0xBF800000, 0x00000000, 0x3F800000, 0x40800000 arrive in order, with no loss or duplication.
- Reset mid-flight: `rst_n` pulsed low while both stages are valid → `rsp_valid` goes low immediately, `busy`=0, `ptr`=0, and the next grant goes to req0.
- Simultaneous pop and accept with the pipeline full and `rsp_ready=1` → `busy` stays 1 and there is no bubble in `rsp_valid`.
- With `POSIT_TO_FLOAT_ARB_STATS_EN`: 70000 accepts from req0 → `stat_accept[15:0]`=0xFFFF (saturated) and `stat_accept[31:16]`=0.
